pipeline_stall_controller: RTL

//  Generates the PC/pipeline-register hold, flush and bubble controls for the 5-stage MIPS pipeline.
//  It drives the PC register's disable input (1 = hold PC) and the hold/flush inputs of IF/ID, ID/EX and EX/MEM.
//  It resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits and post-reset fill.
//  It also keeps saturating stall/flush counters and a sticky memory-timeout halt.

---
 rtl/pipeline_stall_controller_pkg.sv | 20 ++
 rtl/pipeline_stall_controller_if.sv | 46 ++++
 rtl/pipeline_stall_controller_load_use_detect.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline stall controller:
//   state_e     controller state encoding
//   NOP_INSTR   instruction word loaded into a flushed/bubbled register
//   REG_ADDR_W  register-file address width (rs/rt fields)
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          REG_ADDR_W = 5;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_if
// Groups the hazard inputs and hold/flush/bubble controls exchanged between
// the pipeline datapath and the stall controller.
//   master : datapath side  - drives hazard info, receives controls
//   slave  : controller side - receives hazard info, drives controls
// Hazard info : id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
//               branch_taken, mem_busy
// Controls    : pc_disable, ifid_hold, ifid_flush, idex_bubble,
//               pipe_freeze, halted, stall_count, flush_count
// ---------------------------------------------------------------------------
interface pipeline_stall_if #(
  parameter int CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  branch_taken;
  logic                  mem_busy;

  logic                  pc_disable;
  logic                  ifid_hold;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  pipe_freeze;
  logic                  halted;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    input  pc_disable, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halted,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    output pc_disable, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halted,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator. Flags when the load in EX writes
// a register the ID instruction reads. Register 0 is hard-wired zero, so a
// load targeting it never creates a dependency.
// Ports:
//   id_rs, id_rt   source fields of the ID instruction
//   id_uses_rt     ID instruction actually reads rt
//   ex_mem_read    EX instruction is a load
//   ex_rt          destination of the load in EX
//   lu_hazard      1 = ID must stall one cycle
// ---------------------------------------------------------------------------
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  lu_hazard
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (ex_rt == id_rs);
  assign rt_match_s = id_uses_rt & (ex_rt == id_rt);
  assign lu_hazard  = ex_mem_read & (ex_rt != 5'd0) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Generates PC hold, IF/ID hold/flush, ID/EX bubble and ID/EX+EX/MEM freeze
// for the 5-stage MIPS pipeline. Handles post-reset fill, memory waits,
// taken-branch flushes and load-use stalls, in that priority. Keeps
// saturating stall/flush counters and a sticky memory-timeout halt.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    pipeline_stall_if.slave (hazard inputs in, controls out)
// Controls are combinational from state and inputs so they act in the same
// cycle; state, counters and halted are registered.
// ---------------------------------------------------------------------------
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 3,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_if.slave       bus
);

  localparam int               INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam int               WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e             state_r;
  logic [INIT_W-1:0]  init_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [CNT_W-1:0]   stall_count_r;
  logic [CNT_W-1:0]   flush_count_r;
  logic               halted_r;

  logic               lu_hazard_s;
  logic               pc_disable_s;
  logic               ifid_hold_s;
  logic               ifid_flush_s;
  logic               idex_bubble_s;
  logic               pipe_freeze_s;

  load_use_detect u_load_use_detect (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .lu_hazard   (lu_hazard_s)
  );

  // Same-cycle pipeline controls decoded from state and hazard inputs.
  always_comb begin
    pc_disable_s  = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_freeze_s = 1'b0;
    if (!reset) begin
      // PC held while in reset; everything else released.
      pc_disable_s = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          pc_disable_s  = 1'b1;
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end
        ST_RUN: begin
          if (bus.mem_busy) begin
            pc_disable_s  = 1'b1;
            ifid_hold_s   = 1'b1;
            pipe_freeze_s = 1'b1;
          end else if (bus.branch_taken) begin
            // Flush kills the ID instruction, so any load-use hazard is moot.
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
          end else if (lu_hazard_s) begin
            pc_disable_s  = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_bubble_s = 1'b1;
          end else begin
            pc_disable_s  = 1'b0;
          end
        end
        ST_MEM_WAIT, ST_TIMEOUT: begin
          // EX is frozen; branch/hazard inputs are re-presented after release.
          pc_disable_s  = 1'b1;
          ifid_hold_s   = 1'b1;
          pipe_freeze_s = 1'b1;
        end
        default: begin
          pc_disable_s  = 1'b1;
          ifid_hold_s   = 1'b1;
          pipe_freeze_s = 1'b1;
        end
      endcase
    end
  end

  // State sequencing, wait/fill counters, statistics counters and halt flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_INIT;
      init_cnt_r    <= '0;
      wait_cnt_r    <= '0;
      stall_count_r <= '0;
      flush_count_r <= '0;
      halted_r      <= 1'b0;
    end else begin
      if (pc_disable_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + INIT_W'(1);
          if (init_cnt_r == INIT_LAST) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.mem_busy) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1);
          end else if (bus.branch_taken && (flush_count_r != CNT_MAX)) begin
            flush_count_r <= flush_count_r + CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (!bus.mem_busy) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == WAIT_MAX) begin
            state_r  <= ST_TIMEOUT;
            halted_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.pc_disable  = pc_disable_s;
  assign bus.ifid_hold   = ifid_hold_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_bubble = idex_bubble_s;
  assign bus.pipe_freeze = pipe_freeze_s;
  assign bus.halted      = halted_r;
  assign bus.stall_count = stall_count_r;
  assign bus.flush_count = flush_count_r;

endmodule
